// File: rtl/reg_bank_wb.sv
// 16x16 register file with three bypassed read ports, a committed-write counter
// and a 4-entry write log FIFO with a sticky overflow flag.
module reg_bank_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  input  logic [3:0]  raddr3,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2,
  output logic [15:0] rdata3,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [3:0]  log_addr,
  output logic [15:0] log_data,
  output logic [2:0]  log_count,
  output logic        overflow,
  output logic [15:0] wr_count
);

  logic [15:0] regs      [16];
  logic [3:0]  fifo_addr [4];
  logic [15:0] fifo_data [4];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;

  // Write-through bypass keeps all ports coherent when they alias the write index.
  assign rdata1 = (we && (raddr1 == waddr)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (raddr2 == waddr)) ? wdata : regs[raddr2];
  assign rdata3 = (we && (raddr3 == waddr)) ? wdata : regs[raddr3];

  assign log_valid = (count != 3'd0);
  assign log_count = count;

  // FIFO handshake decode; a full FIFO still accepts a push when the head pops.
  always_comb begin
    full = (count == 3'd4);
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if ((count != 3'd0) && log_ready) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
    if (we && (!full || pop)) begin
      push = 1'b1;
    end else if (we) begin
      drop = 1'b1;
    end else begin
      push = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_next = count + 3'd1;
      2'b01:   count_next = count - 3'd1;
      default: count_next = count;
    endcase
  end

  // Head entry is masked to zero while the log is empty.
  always_comb begin
    log_addr = 4'd0;
    log_data = 16'd0;
    if (log_valid) begin
      log_addr = fifo_addr[head];
      log_data = fifo_data[head];
    end else begin
      log_addr = 4'd0;
      log_data = 16'd0;
    end
  end

  // Register file and commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'd0;
      end
      wr_count <= 16'd0;
    end else if (we) begin
      regs[waddr] <= wdata;
      wr_count    <= wr_count + 16'd1;
    end
  end

  // Write log storage, pointers and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_addr[i] <= 4'd0;
        fifo_data[i] <= 16'd0;
      end
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr[tail] <= waddr;
        fifo_data[tail] <= wdata;
        tail            <= tail + 2'd1;
      end
      if (pop) begin
        head <= head + 2'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed self-checking bench for reg_bank_wb with hand-computed expectations.
module tb_reg_bank_wb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [3:0]  raddr1, raddr2, raddr3;
  logic [15:0] rdata1, rdata2, rdata3;
  logic        log_valid;
  logic        log_ready;
  logic [3:0]  log_addr;
  logic [15:0] log_data;
  logic [2:0]  log_count;
  logic        overflow;
  logic [15:0] wr_count;

  int n_compared;
  int n_mismatched;

  reg_bank_wb dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_data(log_data), .log_count(log_count), .overflow(overflow),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Short asynchronous reset pulse entirely between edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [3:0] a, input logic [15:0] d);
    check_value({tag, "_addr"}, {28'd0, log_addr}, {28'd0, a});
    check_value({tag, "_data"}, {16'd0, log_data}, {16'd0, d});
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1; we = 1'b0; waddr = 4'd0; wdata = 16'd0;
    raddr1 = 4'd0; raddr2 = 4'd0; raddr3 = 4'd0; log_ready = 1'b0;

    // Reset state
    #12;
    check_value("rst_log_valid", {31'd0, log_valid}, 32'd0);
    check_value("rst_log_count", {29'd0, log_count}, 32'd0);
    check_value("rst_overflow",  {31'd0, overflow}, 32'd0);
    check_value("rst_wr_count",  {16'd0, wr_count}, 32'd0);
    check_head("rst_head", 4'd0, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr1 = i[3:0];
      raddr2 = 4'(15 - i);
      #1;
      check_value("rst_reg_p1", {16'd0, rdata1}, 32'd0);
      check_value("rst_reg_p2", {16'd0, rdata2}, 32'd0);
    end

    // Bypass on all three ports; push on empty with log_ready=1 must not bypass
    tick();
    we = 1'b1; waddr = 4'd5; wdata = 16'h1234;
    raddr1 = 4'd5; raddr2 = 4'd5; raddr3 = 4'd5; log_ready = 1'b1;
    #1;
    check_value("byp_rdata1", {16'd0, rdata1}, 32'h1234);
    check_value("byp_rdata2", {16'd0, rdata2}, 32'h1234);
    check_value("byp_rdata3", {16'd0, rdata3}, 32'h1234);
    check_value("byp_log_valid_pre", {31'd0, log_valid}, 32'd0);
    tick();
    we = 1'b0; log_ready = 1'b0;
    #1;
    check_value("wr_rdata1", {16'd0, rdata1}, 32'h1234);
    check_value("wr_rdata3", {16'd0, rdata3}, 32'h1234);
    check_value("wr_log_valid", {31'd0, log_valid}, 32'd1);
    check_value("wr_log_count", {29'd0, log_count}, 32'd1);
    check_head("wr_head", 4'd5, 16'h1234);
    check_value("wr_count_1", {16'd0, wr_count}, 32'd1);

    // Fill to full and overflow with log_ready=0
    pulse_reset();
    tick();
    for (int i = 1; i <= 5; i++) begin
      we = 1'b1; waddr = i[3:0]; wdata = 16'(i * 16'h0011);
      if (i == 5) begin
        #1;
        check_value("full_count_pre", {29'd0, log_count}, 32'd4);
        check_value("full_ovf_pre", {31'd0, overflow}, 32'd0);
      end
      tick();
    end
    we = 1'b0; raddr1 = 4'd5; raddr2 = 4'd1;
    #1;
    check_value("ovf_log_count", {29'd0, log_count}, 32'd4);
    check_value("ovf_flag", {31'd0, overflow}, 32'd1);
    check_value("ovf_r5", {16'd0, rdata1}, 32'h0055);
    check_value("ovf_r1", {16'd0, rdata2}, 32'h0011);
    check_value("ovf_wr_count", {16'd0, wr_count}, 32'd5);
    check_head("ovf_head", 4'd1, 16'h0011);

    // Simultaneous push and pop while full
    we = 1'b1; waddr = 4'd6; wdata = 16'h0066; log_ready = 1'b1;
    tick();
    we = 1'b0; log_ready = 1'b0; raddr1 = 4'd6;
    #1;
    check_value("pp_log_count", {29'd0, log_count}, 32'd4);
    check_head("pp_head", 4'd2, 16'h0022);
    check_value("pp_r6", {16'd0, rdata1}, 32'h0066);
    check_value("pp_wr_count", {16'd0, wr_count}, 32'd6);

    // Drain in order, then pop on empty
    log_ready = 1'b1;
    check_head("drain0", 4'd2, 16'h0022);
    tick();
    check_head("drain1", 4'd3, 16'h0033);
    tick();
    check_head("drain2", 4'd4, 16'h0044);
    tick();
    check_head("drain3", 4'd6, 16'h0066);
    check_value("drain3_count", {29'd0, log_count}, 32'd1);
    tick();
    check_value("drain_count", {29'd0, log_count}, 32'd0);
    check_value("drain_valid", {31'd0, log_valid}, 32'd0);
    check_head("drain_empty", 4'd0, 16'd0);
    check_value("drain_ovf", {31'd0, overflow}, 32'd1);
    tick();
    check_value("empty_pop_count", {29'd0, log_count}, 32'd0);
    check_value("empty_pop_ovf", {31'd0, overflow}, 32'd1);

    // Counter wrap: 0xFFFF writes, then one more
    pulse_reset();
    tick();
    we = 1'b1; waddr = 4'd0; wdata = 16'hBEEF; raddr2 = 4'd0;
    repeat (16'hFFFF) @(posedge clk);
    #2;
    we = 1'b0;
    #1;
    check_value("wrap_ffff", {16'd0, wr_count}, 32'h0000FFFF);
    check_value("wrap_r0", {16'd0, rdata2}, 32'hBEEF);
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    check_value("wrap_zero", {16'd0, wr_count}, 32'd0);
    we = 1'b1;
    tick();

    // Asynchronous reset between edges with a pending write
    waddr = 4'd3; wdata = 16'hA5A5; raddr1 = 4'd3; raddr2 = 4'd0;
    #1;
    check_value("pre_rst_wr_count", {16'd0, wr_count}, 32'd1);
    check_value("pre_rst_r0", {16'd0, rdata2}, 32'hBEEF);
    reset = 1'b1;
    #1;
    check_value("arst_wr_count", {16'd0, wr_count}, 32'd0);
    check_value("arst_r0", {16'd0, rdata2}, 32'd0);
    check_value("arst_bypass", {16'd0, rdata1}, 32'hA5A5);
    check_value("arst_log_valid", {31'd0, log_valid}, 32'd0);
    check_value("arst_log_count", {29'd0, log_count}, 32'd0);
    check_value("arst_ovf", {31'd0, overflow}, 32'd0);
    check_head("arst_head", 4'd0, 16'd0);
    tick();
    reset = 1'b0;
    waddr = 4'd7; wdata = 16'h7777;
    #1;
    check_value("post_rst_r3", {16'd0, rdata1}, 32'd0);
    check_value("post_rst_wr_count", {16'd0, wr_count}, 32'd0);
    tick();
    we = 1'b0; raddr1 = 4'd7;
    #1;
    check_value("first_write_r7", {16'd0, rdata1}, 32'h7777);
    check_value("first_write_count", {16'd0, wr_count}, 32'd1);
    check_head("first_write_head", 4'd7, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
